// File: rtl/mem_stage_pkg.sv
// Shared encodings, payload structs and access-legality helper for the RISC-V memory stage.
package mem_stage_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned ALEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned BE_W   = XLEN / 8;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  typedef struct packed {
    logic              reg_write;
    logic              mem_write;
    logic [1:0]        res_src;
    logic [2:0]        funct3;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   write_data;
    logic [REG_AW-1:0] rd;
    logic [ALEN-1:0]   pc_plus4;
  } ex_mem_t;

  typedef struct packed {
    logic              reg_write;
    logic [1:0]        res_src;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   read_data;
    logic [ALEN-1:0]   pc_plus4;
    logic              misalign;
  } mem_wb_t;

  // True when funct3 is a valid size code for the direction and the address is naturally aligned.
  function automatic logic access_legal(input logic       is_store,
                                        input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
    logic code_ok;
    logic align_ok;
    if (is_store) begin
      code_ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    end else begin
      code_ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                (funct3 == F3_BU) || (funct3 == F3_HU);
    end
    case (funct3[1:0])
      SZ_H:    align_ok = ~addr_lo[0];
      SZ_W:    align_ok = (addr_lo == 2'b00);
      default: align_ok = 1'b1;
    endcase
    return code_ok & align_ok;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Variable-latency req/ack data-memory port between the memory stage and data memory.
interface mem_stage_if #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 32
) ();

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  logic                     dmem_req;
  logic                     dmem_we;
  logic [ADDRESS_WIDTH-1:0] dmem_addr;
  logic [BE_WIDTH-1:0]      dmem_be;
  logic [DATA_WIDTH-1:0]    dmem_wdata;
  logic                     dmem_ack;
  logic [DATA_WIDTH-1:0]    dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_be,
    output dmem_wdata,
    input  dmem_ack,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_be,
    input  dmem_wdata,
    output dmem_ack,
    output dmem_rdata
  );

endinterface

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane steering for stores and lane extraction with sign/zero extension for loads.
module lsu_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] load_word,
  output logic [BE_W-1:0] be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  assign lane_byte = load_word[{addr_lo, 3'b000} +: 8];
  assign lane_half = addr_lo[1] ? load_word[31:16] : load_word[15:0];

  // funct3[2] selects zero extension (LBU/LHU); low bits give the access size.
  always_comb begin
    be        = '1;
    wdata     = store_data;
    load_data = load_word;
    case (funct3[1:0])
      SZ_B: begin
        be        = BE_W'(4'b0001 << addr_lo);
        wdata     = {4{store_data[7:0]}};
        load_data = funct3[2] ? {24'b0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
      end
      SZ_H: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata     = {2{store_data[15:0]}};
        load_data = funct3[2] ? {16'b0, lane_half} : {{16{lane_half[15]}}, lane_half};
      end
      default: begin
        be        = '1;
        wdata     = store_data;
        load_data = load_word;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RISC-V memory stage: EX/MEM and MEM/WB registers around a req/ack data-memory access FSM.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     reg_write_e,
  input  logic                     mem_write_e,
  input  logic [1:0]               res_src_e,
  input  logic [2:0]               funct3_e,
  input  logic [DATA_WIDTH-1:0]    alu_result_e,
  input  logic [DATA_WIDTH-1:0]    write_data_e,
  input  logic [4:0]               rd_e,
  input  logic [ADDRESS_WIDTH-1:0] pc_plus4_e,
  mem_stage_if.master              dmem,
  output logic                     busy_m,
  output logic                     reg_write_m,
  output logic [4:0]               rd_m,
  output logic [DATA_WIDTH-1:0]    alu_result_m,
  output logic                     reg_write_w,
  output logic [1:0]               res_src_w,
  output logic [4:0]               rd_w,
  output logic [DATA_WIDTH-1:0]    alu_result_w,
  output logic [DATA_WIDTH-1:0]    read_data_w,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_w,
  output logic                     misalign_w
);

  logic [0:0]      state_q;
  logic [0:0]      state_d;
  ex_mem_t         ex_mem_q;
  ex_mem_t         ex_mem_d;
  mem_wb_t         mem_wb_q;
  mem_wb_t         mem_wb_d;

  logic            legal_mem_e;
  logic            load_m;
  logic            store_m;
  logic            err_m;
  logic [BE_W-1:0] be_c;
  logic [XLEN-1:0] wdata_c;
  logic [XLEN-1:0] load_data_c;

  // A legal access entering M is what starts (or continues) a memory transaction.
  assign legal_mem_e = ((res_src_e == RES_MEM) | mem_write_e) &
                       access_legal(mem_write_e, funct3_e, alu_result_e[1:0]);

  assign load_m  = (ex_mem_q.res_src == RES_MEM);
  assign store_m = ex_mem_q.mem_write;
  assign err_m   = (load_m | store_m) &
                   ~access_legal(store_m, ex_mem_q.funct3, ex_mem_q.alu_result[1:0]);

  // Combinational from ack so a zero-wait memory never stalls the pipe.
  assign busy_m = (state_q == ST_ACCESS) & ~dmem.dmem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (legal_mem_e) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (dmem.dmem_ack) state_d = legal_mem_e ? ST_ACCESS : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  lsu_align u_lsu_align (
    .funct3     (ex_mem_q.funct3),
    .addr_lo    (ex_mem_q.alu_result[1:0]),
    .store_data (ex_mem_q.write_data),
    .load_word  (dmem.dmem_rdata),
    .be         (be_c),
    .wdata      (wdata_c),
    .load_data  (load_data_c)
  );

  // Request fields come straight from EX/MEM, which holds while the access is outstanding.
  assign dmem.dmem_req   = (state_q == ST_ACCESS);
  assign dmem.dmem_we    = store_m;
  assign dmem.dmem_addr  = ADDRESS_WIDTH'({ex_mem_q.alu_result[XLEN-1:2], 2'b00});
  assign dmem.dmem_be    = be_c;
  assign dmem.dmem_wdata = wdata_c;

  always_comb begin
    ex_mem_d = ex_mem_q;
    if (!busy_m) begin
      ex_mem_d.reg_write  = reg_write_e;
      ex_mem_d.mem_write  = mem_write_e;
      ex_mem_d.res_src    = res_src_e;
      ex_mem_d.funct3     = funct3_e;
      ex_mem_d.alu_result = XLEN'(alu_result_e);
      ex_mem_d.write_data = XLEN'(write_data_e);
      ex_mem_d.rd         = rd_e;
      ex_mem_d.pc_plus4   = ALEN'(pc_plus4_e);
    end
  end

  // A stall cycle pushes an all-zero bubble into W.
  always_comb begin
    mem_wb_d = '0;
    if (!busy_m) begin
      mem_wb_d.reg_write  = ex_mem_q.reg_write & ~err_m;
      mem_wb_d.res_src    = ex_mem_q.res_src;
      mem_wb_d.rd         = ex_mem_q.rd;
      mem_wb_d.alu_result = ex_mem_q.alu_result;
      mem_wb_d.read_data  = (load_m & ~err_m) ? load_data_c : '0;
      mem_wb_d.pc_plus4   = ex_mem_q.pc_plus4;
      mem_wb_d.misalign   = err_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

  assign reg_write_m  = ex_mem_q.reg_write;
  assign rd_m         = ex_mem_q.rd;
  assign alu_result_m = DATA_WIDTH'(ex_mem_q.alu_result);

  assign reg_write_w  = mem_wb_q.reg_write;
  assign res_src_w    = mem_wb_q.res_src;
  assign rd_w         = mem_wb_q.rd;
  assign alu_result_w = DATA_WIDTH'(mem_wb_q.alu_result);
  assign read_data_w  = DATA_WIDTH'(mem_wb_q.read_data);
  assign pc_plus4_w   = ADDRESS_WIDTH'(mem_wb_q.pc_plus4);
  assign misalign_w   = mem_wb_q.misalign;

endmodule

// File: tb/tb_mem_stage.sv
// Directed table-driven bench for mem_stage plus back-to-back and reset corner sequences.
module tb_mem_stage;

  logic        clk;
  logic        rst_n;
  logic        reg_write_e;
  logic        mem_write_e;
  logic [1:0]  res_src_e;
  logic [2:0]  funct3_e;
  logic [31:0] alu_result_e;
  logic [31:0] write_data_e;
  logic [4:0]  rd_e;
  logic [31:0] pc_plus4_e;
  logic        busy_m;
  logic        reg_write_m;
  logic [4:0]  rd_m;
  logic [31:0] alu_result_m;
  logic        reg_write_w;
  logic [1:0]  res_src_w;
  logic [4:0]  rd_w;
  logic [31:0] alu_result_w;
  logic [31:0] read_data_w;
  logic [31:0] pc_plus4_w;
  logic        misalign_w;

  mem_stage_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) dmem_bus ();

  mem_stage #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .reg_write_e  (reg_write_e),
    .mem_write_e  (mem_write_e),
    .res_src_e    (res_src_e),
    .funct3_e     (funct3_e),
    .alu_result_e (alu_result_e),
    .write_data_e (write_data_e),
    .rd_e         (rd_e),
    .pc_plus4_e   (pc_plus4_e),
    .dmem         (dmem_bus),
    .busy_m       (busy_m),
    .reg_write_m  (reg_write_m),
    .rd_m         (rd_m),
    .alu_result_m (alu_result_m),
    .reg_write_w  (reg_write_w),
    .res_src_w    (res_src_w),
    .rd_w         (rd_w),
    .alu_result_w (alu_result_w),
    .read_data_w  (read_data_w),
    .pc_plus4_w   (pc_plus4_w),
    .misalign_w   (misalign_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic        mw;
    logic [1:0]  rs;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic [31:0] pc4;
    int          wait_cyc;
    logic [31:0] rdata;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_rw;
    logic [31:0] exp_rdw;
    logic        exp_mis;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];
  vec_t v;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t x);
    reg_write_e  = x.rw;
    mem_write_e  = x.mw;
    res_src_e    = x.rs;
    funct3_e     = x.f3;
    alu_result_e = x.alu;
    write_data_e = x.wd;
    rd_e         = x.rd;
    pc_plus4_e   = x.pc4;
  endtask

  task automatic drive_nop();
    reg_write_e  = 1'b0;
    mem_write_e  = 1'b0;
    res_src_e    = 2'b00;
    funct3_e     = 3'b000;
    alu_result_e = 32'h0;
    write_data_e = 32'h0;
    rd_e         = 5'd0;
    pc_plus4_e   = 32'h0;
  endtask

  task automatic drive_op(input logic rw, input logic mw, input logic [1:0] rs, input logic [2:0] f3,
                          input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                          input logic [31:0] pc4);
    reg_write_e  = rw;
    mem_write_e  = mw;
    res_src_e    = rs;
    funct3_e     = f3;
    alu_result_e = alu;
    write_data_e = wd;
    rd_e         = rd;
    pc_plus4_e   = pc4;
  endtask

  initial begin
    //          rw    mw    rs     f3      alu           wd            rd     pc4        wt rdata         req   addr          be       wdata         erw   rdw           mis
    vecs[0]  = '{1'b1, 1'b0, 2'b00, 3'b000, 32'h00001234, 32'h00000055, 5'd5,  32'h104, 0, 32'h00000000, 1'b0, 32'h0,        4'b0000, 32'h0,        1'b1, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 2'b00, 3'b000, 32'h00001003, 32'h000000AB, 5'd0,  32'h108, 2, 32'h00000000, 1'b1, 32'h00001000, 4'b1000, 32'hABABABAB, 1'b0, 32'h00000000, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 2'b01, 3'b000, 32'h00002002, 32'h00000000, 5'd6,  32'h10C, 1, 32'h00800000, 1'b1, 32'h00002000, 4'b0100, 32'h00000000, 1'b1, 32'hFFFFFF80, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 2'b01, 3'b100, 32'h00002002, 32'h00000000, 5'd7,  32'h110, 0, 32'h00800000, 1'b1, 32'h00002000, 4'b0100, 32'h00000000, 1'b1, 32'h00000080, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 2'b01, 3'b001, 32'h00002002, 32'h00000000, 5'd8,  32'h114, 0, 32'h80010000, 1'b1, 32'h00002000, 4'b1100, 32'h00000000, 1'b1, 32'hFFFF8001, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 2'b01, 3'b010, 32'h00003001, 32'h00000000, 5'd9,  32'h118, 0, 32'h00000000, 1'b0, 32'h0,        4'b0000, 32'h0,        1'b0, 32'h00000000, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 2'b01, 3'b011, 32'h00003000, 32'h00000000, 5'd10, 32'h11C, 0, 32'h00000000, 1'b0, 32'h0,        4'b0000, 32'h0,        1'b0, 32'h00000000, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 2'b00, 3'b001, 32'h00004002, 32'h1234CDEF, 5'd0,  32'h120, 1, 32'h00000000, 1'b1, 32'h00004000, 4'b1100, 32'hCDEFCDEF, 1'b0, 32'h00000000, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 2'b00, 3'b010, 32'h00005000, 32'hDEADBEEF, 5'd0,  32'h124, 0, 32'h00000000, 1'b1, 32'h00005000, 4'b1111, 32'hDEADBEEF, 1'b0, 32'h00000000, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 2'b01, 3'b101, 32'h00006000, 32'h00000000, 5'd11, 32'h128, 3, 32'h1234F00D, 1'b1, 32'h00006000, 4'b0011, 32'h00000000, 1'b1, 32'h0000F00D, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 2'b01, 3'b010, 32'h00007004, 32'h00000000, 5'd12, 32'h12C, 0, 32'hCAFEBABE, 1'b1, 32'h00007004, 4'b1111, 32'h00000000, 1'b1, 32'hCAFEBABE, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 2'b10, 3'b000, 32'h00000300, 32'h00000000, 5'd1,  32'h200, 0, 32'h00000000, 1'b0, 32'h0,        4'b0000, 32'h0,        1'b1, 32'h00000000, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 2'b00, 3'b001, 32'h00004001, 32'h00001111, 5'd0,  32'h130, 0, 32'h00000000, 1'b0, 32'h0,        4'b0000, 32'h0,        1'b0, 32'h00000000, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 2'b00, 3'b011, 32'h00000000, 32'h00002222, 5'd0,  32'h134, 0, 32'h00000000, 1'b0, 32'h0,        4'b0000, 32'h0,        1'b0, 32'h00000000, 1'b1};

    rst_n = 1'b0;
    drive_nop();
    dmem_bus.dmem_ack   = 1'b0;
    dmem_bus.dmem_rdata = 32'h0;

    #12;
    chk("reset dmem_req", 32'(dmem_bus.dmem_req), 32'h0);
    chk("reset busy_m", 32'(busy_m), 32'h0);
    chk("reset reg_write_w", 32'(reg_write_w), 32'h0);
    chk("reset alu_result_m", alu_result_m, 32'h0);
    chk("reset misalign_w", 32'(misalign_w), 32'h0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      drive(v);
      dmem_bus.dmem_ack   = 1'b0;
      dmem_bus.dmem_rdata = v.rdata;
      tick();
      drive_nop();
      chk($sformatf("v%0d reg_write_m", i), 32'(reg_write_m), 32'(v.rw));
      chk($sformatf("v%0d rd_m", i), 32'(rd_m), 32'(v.rd));
      chk($sformatf("v%0d alu_result_m", i), alu_result_m, v.alu);
      chk($sformatf("v%0d dmem_req", i), 32'(dmem_bus.dmem_req), 32'(v.exp_req));
      if (v.exp_req) begin
        chk($sformatf("v%0d dmem_addr", i), dmem_bus.dmem_addr, v.exp_addr);
        chk($sformatf("v%0d dmem_be", i), 32'(dmem_bus.dmem_be), 32'(v.exp_be));
        chk($sformatf("v%0d dmem_wdata", i), dmem_bus.dmem_wdata, v.exp_wdata);
        chk($sformatf("v%0d dmem_we", i), 32'(dmem_bus.dmem_we), 32'(v.mw));
        for (int w = 0; w < v.wait_cyc; w++) begin
          chk($sformatf("v%0d busy_m stall%0d", i, w), 32'(busy_m), 32'h1);
          tick();
          chk($sformatf("v%0d bubble reg_write_w %0d", i, w), 32'(reg_write_w), 32'h0);
          chk($sformatf("v%0d bubble misalign_w %0d", i, w), 32'(misalign_w), 32'h0);
          chk($sformatf("v%0d req held %0d", i, w), 32'(dmem_bus.dmem_req), 32'h1);
          chk($sformatf("v%0d addr held %0d", i, w), dmem_bus.dmem_addr, v.exp_addr);
        end
        dmem_bus.dmem_ack = 1'b1;
        #1;
        chk($sformatf("v%0d busy_m on ack", i), 32'(busy_m), 32'h0);
        tick();
        dmem_bus.dmem_ack = 1'b0;
      end else begin
        chk($sformatf("v%0d busy_m", i), 32'(busy_m), 32'h0);
        tick();
      end
      chk($sformatf("v%0d reg_write_w", i), 32'(reg_write_w), 32'(v.exp_rw));
      chk($sformatf("v%0d rd_w", i), 32'(rd_w), 32'(v.rd));
      chk($sformatf("v%0d res_src_w", i), 32'(res_src_w), 32'(v.rs));
      chk($sformatf("v%0d alu_result_w", i), alu_result_w, v.alu);
      chk($sformatf("v%0d read_data_w", i), read_data_w, v.exp_rdw);
      chk($sformatf("v%0d pc_plus4_w", i), pc_plus4_w, v.pc4);
      chk($sformatf("v%0d misalign_w", i), 32'(misalign_w), 32'(v.exp_mis));
      chk($sformatf("v%0d req idle", i), 32'(dmem_bus.dmem_req), 32'h0);
    end

    // Back-to-back zero-wait loads: req never drops, no stall, consecutive retirement.
    drive_op(1'b1, 1'b0, 2'b01, 3'b010, 32'h00000100, 32'h0, 5'd1, 32'h400);
    tick();
    drive_op(1'b1, 1'b0, 2'b01, 3'b010, 32'h00000104, 32'h0, 5'd2, 32'h404);
    dmem_bus.dmem_ack   = 1'b1;
    dmem_bus.dmem_rdata = 32'h11111111;
    #1;
    chk("b2b req first", 32'(dmem_bus.dmem_req), 32'h1);
    chk("b2b addr first", dmem_bus.dmem_addr, 32'h00000100);
    chk("b2b busy first", 32'(busy_m), 32'h0);
    tick();
    drive_nop();
    dmem_bus.dmem_rdata = 32'h22222222;
    #1;
    chk("b2b req second", 32'(dmem_bus.dmem_req), 32'h1);
    chk("b2b addr second", dmem_bus.dmem_addr, 32'h00000104);
    chk("b2b busy second", 32'(busy_m), 32'h0);
    chk("b2b rd_w first", 32'(rd_w), 32'd1);
    chk("b2b read_data_w first", read_data_w, 32'h11111111);
    chk("b2b reg_write_w first", 32'(reg_write_w), 32'h1);
    tick();
    dmem_bus.dmem_ack = 1'b0;
    chk("b2b rd_w second", 32'(rd_w), 32'd2);
    chk("b2b read_data_w second", read_data_w, 32'h22222222);
    chk("b2b req drops", 32'(dmem_bus.dmem_req), 32'h0);

    // Reset mid-access abandons the store and clears every output at once.
    drive_op(1'b1, 1'b0, 2'b00, 3'b000, 32'h00000099, 32'h0, 5'd3, 32'h44);
    tick();
    drive_op(1'b0, 1'b1, 2'b00, 3'b010, 32'h00000800, 32'h00000001, 5'd0, 32'h48);
    tick();
    drive_nop();
    chk("rst pre req", 32'(dmem_bus.dmem_req), 32'h1);
    chk("rst pre alu_result_w", alu_result_w, 32'h00000099);
    rst_n = 1'b0;
    #1;
    chk("rst req", 32'(dmem_bus.dmem_req), 32'h0);
    chk("rst busy_m", 32'(busy_m), 32'h0);
    chk("rst alu_result_m", alu_result_m, 32'h0);
    chk("rst alu_result_w", alu_result_w, 32'h0);
    chk("rst pc_plus4_w", pc_plus4_w, 32'h0);
    chk("rst reg_write_w", 32'(reg_write_w), 32'h0);
    #3;
    rst_n = 1'b1;
    tick();
    dmem_bus.dmem_ack = 1'b1;
    #1;
    chk("stray ack busy_m", 32'(busy_m), 32'h0);
    chk("stray ack req", 32'(dmem_bus.dmem_req), 32'h0);
    tick();
    dmem_bus.dmem_ack = 1'b0;
    chk("stray ack req after", 32'(dmem_bus.dmem_req), 32'h0);
    chk("stray ack reg_write_w", 32'(reg_write_w), 32'h0);
    chk("stray ack misalign_w", 32'(misalign_w), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
